// File: rtl/exec_multi.sv
// exec_multi: multi-channel execute dispatcher.
// Routes one decoded op per cycle to a one-hot selected functional unit,
// tracks each unit with a small IDLE/RUN/HOLD machine, and drains finished
// results to register_manage through a round-robin write-back arbiter.
//
// Handshake: an op moves from inst_window to unit i only in a cycle where
// unit_order[i] and unit_accepted[i] are both high; accepted mirrors that
// transfer back to inst_window. unit_done[i] is a one-cycle pulse that is
// honoured only while unit i is RUN (or in the same cycle as its accept).
module exec_multi #(
    parameter int NUM_UNITS     = 9,
    parameter int LEN_WORD      = 32,
    parameter int LEN_PREG_ADDR = 6
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          order,
    output logic                          accepted,
    input  logic [NUM_UNITS-1:0]          unit_sel,
    input  logic [LEN_PREG_ADDR-1:0]      pa_rd_in,
    output logic [NUM_UNITS-1:0]          unit_order,
    input  logic [NUM_UNITS-1:0]          unit_accepted,
    input  logic [NUM_UNITS-1:0]          unit_done,
    input  logic [NUM_UNITS*LEN_WORD-1:0] unit_rd,
    output logic                          wb_valid,
    output logic [LEN_PREG_ADDR-1:0]      wb_pa,
    output logic [LEN_WORD-1:0]           wb_data,
    output logic [NUM_UNITS-1:0]          unit_busy_out,
    output logic                          busy_out
);

    localparam int PTR_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } unit_state_t;

    // Per-unit machine state; kept as a named array so checkers can bind to it.
    unit_state_t                state      [NUM_UNITS];
    unit_state_t                state_next [NUM_UNITS];
    logic [LEN_PREG_ADDR-1:0]   tag        [NUM_UNITS];
    logic [LEN_WORD-1:0]        res        [NUM_UNITS];
    logic [PTR_W-1:0]           rr_ptr;

    logic [NUM_UNITS-1:0]       idle_vec;
    logic [NUM_UNITS-1:0]       hold_vec;
    logic [NUM_UNITS-1:0]       take_vec;
    logic [NUM_UNITS-1:0]       grant_oh;
    logic                       grant_valid;
    logic [PTR_W-1:0]           grant_idx;
    logic                       sel_onehot;
    logic                       legal;

    // State register: all unit machines return to IDLE on reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NUM_UNITS; i++) state[i] <= ST_IDLE;
        end else begin
            for (int i = 0; i < NUM_UNITS; i++) state[i] <= state_next[i];
        end
    end

    // Next-state logic; an accept with a same-cycle done skips RUN entirely.
    always_comb begin
        for (int i = 0; i < NUM_UNITS; i++) begin
            state_next[i] = state[i];
            case (state[i])
                ST_IDLE: if (take_vec[i]) state_next[i] = unit_done[i] ? ST_HOLD : ST_RUN;
                ST_RUN:  if (unit_done[i]) state_next[i] = ST_HOLD;
                ST_HOLD: if (grant_oh[i]) state_next[i] = ST_IDLE;
                default: state_next[i] = ST_IDLE;
            endcase
        end
    end

    // Output logic: state decode into occupancy and arbiter candidates.
    always_comb begin
        for (int i = 0; i < NUM_UNITS; i++) begin
            idle_vec[i]      = (state[i] == ST_IDLE);
            hold_vec[i]      = (state[i] == ST_HOLD);
            unit_busy_out[i] = (state[i] != ST_IDLE);
        end
        busy_out = |unit_busy_out;
    end

    // Dispatch: only an exactly one-hot select onto an idle unit is ordered.
    always_comb begin
        sel_onehot = (unit_sel != '0) && ((unit_sel & (unit_sel - NUM_UNITS'(1))) == '0);
        legal      = order && sel_onehot && ((unit_sel & idle_vec) != '0);
        unit_order = legal ? unit_sel : '0;
        take_vec   = unit_order & unit_accepted;
        accepted   = |take_vec;
    end

    // Round-robin arbiter: first HOLD unit at or after rr_ptr, wrapping explicitly.
    always_comb begin
        int idx;
        idx         = 0;
        grant_valid = 1'b0;
        grant_idx   = '0;
        grant_oh    = '0;
        for (int off = 0; off < NUM_UNITS; off++) begin
            idx = int'(rr_ptr) + off;
            if (idx >= NUM_UNITS) idx = idx - NUM_UNITS;
            if (!grant_valid && hold_vec[idx]) begin
                grant_valid   = 1'b1;
                grant_idx     = PTR_W'(idx);
                grant_oh[idx] = 1'b1;
            end
        end
    end

    // Datapath: capture tags/results, advance the pointer, register write-back.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NUM_UNITS; i++) begin
                tag[i] <= '0;
                res[i] <= '0;
            end
            rr_ptr   <= '0;
            wb_valid <= 1'b0;
            wb_pa    <= '0;
            wb_data  <= '0;
        end else begin
            for (int i = 0; i < NUM_UNITS; i++) begin
                if (take_vec[i]) tag[i] <= pa_rd_in;
                if (unit_done[i] && (take_vec[i] || state[i] == ST_RUN))
                    res[i] <= unit_rd[i*LEN_WORD +: LEN_WORD];
            end
            wb_valid <= grant_valid;
            if (grant_valid) begin
                wb_pa   <= tag[grant_idx];
                wb_data <= res[grant_idx];
                rr_ptr  <= (grant_idx == PTR_W'(NUM_UNITS - 1)) ? '0 : grant_idx + PTR_W'(1);
            end
        end
    end

endmodule
